// File: rtl/pg_mcast_route_stage.sv
// Registered route stage: computes {B,E,S,W,N} and serialises
// multicast into unicast copies that detour around a faulty node.
// Ports: in_* valid/ready packet in, pg_* fault info, out_* beat out,
// out_route_req route request, drop_pulse on discard.
module pg_mcast_route_stage #(
  parameter int MESH_X    = 8,
  parameter int MESH_Y    = 8,
  parameter int COORD_W   = 3,
  parameter int PAYLOAD_W = 32,
  parameter int LOCAL_X   = 0,
  parameter int LOCAL_Y   = 0,
  parameter int ROUTER_ID = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COORD_W-1:0]   in_tgt_x,
  input  logic [COORD_W-1:0]   in_tgt_y,
  input  logic [COORD_W-1:0]   in_src_x,
  input  logic [COORD_W-1:0]   in_src_y,
  input  logic [1:0]           in_pkt_type,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 pg_en,
  input  logic [COORD_W-1:0]   pg_node_x,
  input  logic [COORD_W-1:0]   pg_node_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COORD_W-1:0]   out_tgt_x,
  output logic [COORD_W-1:0]   out_tgt_y,
  output logic [COORD_W-1:0]   out_src_x,
  output logic [COORD_W-1:0]   out_src_y,
  output logic [1:0]           out_pkt_type,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [4:0]           out_route_req,
  output logic                 drop_pulse
);

  typedef logic [COORD_W-1:0] crd_t;
  typedef enum logic {IDLE, REPL} state_t;

  localparam crd_t LX   = crd_t'(LOCAL_X);
  localparam crd_t LY   = crd_t'(LOCAL_Y);
  localparam crd_t XMAX = crd_t'(MESH_X - 1);
  localparam crd_t YMAX = crd_t'(MESH_Y - 1);
  localparam crd_t ONE  = crd_t'(1);
  localparam logic [4:0] ARR =
    (ROUTER_ID < 4) ? 5'(1 << ROUTER_ID) : 5'd0;
  localparam logic [4:0] EDGE =
    {1'b0, LX == XMAX, LY == '0, LX == '0, LY == YMAX};

  // Step a copy position; {fin, x, y}, fin = no further copy.
  function automatic logic [2*COORD_W:0] adv(
    input logic [1:0] t,
    input crd_t       x,
    input crd_t       y
  );
    logic fin;
    crd_t nx;
    crd_t ny;
    fin = 1'b0;
    nx  = x;
    ny  = y;
    case (t)
      2'b01: if (y == YMAX) fin = 1'b1;
             else ny = y + ONE;
      2'b10: if (x == XMAX) fin = 1'b1;
             else nx = x + ONE;
      default: begin
        if (x != XMAX) nx = x + ONE;
        else if (y == YMAX) fin = 1'b1;
        else begin
          nx = '0;
          ny = y + ONE;
        end
      end
    endcase
    return {fin, nx, ny};
  endfunction

  function automatic logic [4:0] route(
    input crd_t       tx,
    input crd_t       ty,
    input crd_t       sx,
    input crd_t       sy,
    input logic [1:0] t,
    input logic       pg,
    input crd_t       fx,
    input crd_t       fy
  );
    logic n, s, e, w, b;
    logic fe, fw, fn, fs;
    logic [4:0] r;
    n = 1'b0; s = 1'b0; e = 1'b0;
    w = 1'b0; b = 1'b0;
    case (t)
      2'b00: begin
        e = tx > LX;
        w = tx < LX;
        n = (tx == LX) && (ty > LY);
        s = (tx == LX) && (ty < LY);
        b = (tx == LX) && (ty == LY);
      end
      2'b01: begin
        e = tx > LX;
        w = tx < LX;
        n = tx == LX;
        s = tx == LX;
        b = tx == LX;
      end
      2'b10: begin
        e = (sy == LY) && (LX >= sx);
        w = (sy == LY) && (LX <= sx);
        n = ty > LY;
        s = ty < LY;
        b = ty == LY;
      end
      default: begin
        b = 1'b1;
        n = LY >= sy;
        s = LY <= sy;
        e = LX >= sx;
        w = LX <= sx;
      end
    endcase
    r = {b, e, s, w, n};
    if (t != 2'b00) r = r & ~ARR;
    // Fault sits on the XY next hop in each direction.
    fe = (fy == LY) && (LX != XMAX) && (fx == LX + ONE);
    fw = (fy == LY) && (LX != '0) && (fx == LX - ONE);
    fn = (fx == LX) && (LY != YMAX) && (fy == LY + ONE);
    fs = (fx == LX) && (LY != '0) && (fy == LY - ONE);
    if (pg && t == 2'b00) begin
      if ((e && fe) || (w && fw))
        r = (LY != YMAX) ? 5'b00001 : 5'b00100;
      else if ((n && fn) || (s && fs))
        r = (LX == '0) ? 5'b01000 : 5'b00010;
    end
    return r & ~EDGE;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] typ_q;
  crd_t       fx_q, fy_q;
  logic       acc, mc, drop_in;
  crd_t       f0_x, f0_y, f_x, f_y;
  logic       f_fin;
  crd_t       a_x, a_y, n_x, n_y;
  logic       a_fin, n_fin;
  logic [4:0] r_in, r_f, r_n;

  assign in_ready = (state_q == IDLE) &&
                    (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign mc  = pg_en && (in_pkt_type != 2'b00);
  assign drop_in = pg_en && (in_pkt_type == 2'b00) &&
                   (in_tgt_x == pg_node_x) &&
                   (in_tgt_y == pg_node_y);

  always_comb begin
    f0_x = '0;
    f0_y = '0;
    case (in_pkt_type)
      2'b01:   f0_x = in_tgt_x;
      2'b10:   f0_y = in_tgt_y;
      default: ;
    endcase
    f_fin = 1'b0;
    f_x   = f0_x;
    f_y   = f0_y;
    if (f0_x == pg_node_x && f0_y == pg_node_y)
      {f_fin, f_x, f_y} = adv(in_pkt_type, f0_x, f0_y);
    {a_fin, a_x, a_y} = adv(typ_q, out_tgt_x, out_tgt_y);
    n_fin = a_fin;
    n_x   = a_x;
    n_y   = a_y;
    if (!a_fin && a_x == fx_q && a_y == fy_q)
      {n_fin, n_x, n_y} = adv(typ_q, a_x, a_y);
  end

  assign r_in = route(in_tgt_x, in_tgt_y, in_src_x, in_src_y,
                      in_pkt_type, pg_en, pg_node_x, pg_node_y);
  assign r_f  = route(f_x, f_y, in_src_x, in_src_y,
                      2'b00, 1'b1, pg_node_x, pg_node_y);
  assign r_n  = route(n_x, n_y, out_src_x, out_src_y,
                      2'b00, 1'b1, fx_q, fy_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (acc && mc && !f_fin) state_d = REPL;
      REPL: if (out_ready && n_fin) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_tgt_x     <= '0;
      out_tgt_y     <= '0;
      out_src_x     <= '0;
      out_src_y     <= '0;
      out_pkt_type  <= '0;
      out_payload   <= '0;
      out_route_req <= '0;
      drop_pulse    <= 1'b0;
      typ_q         <= '0;
      fx_q          <= '0;
      fy_q          <= '0;
    end else begin
      drop_pulse <= 1'b0;
      if (acc) begin
        if (mc && f_fin) begin
          drop_pulse <= 1'b1;
          out_valid  <= 1'b0;
        end else if (mc) begin
          out_valid     <= 1'b1;
          out_tgt_x     <= f_x;
          out_tgt_y     <= f_y;
          out_src_x     <= in_src_x;
          out_src_y     <= in_src_y;
          out_pkt_type  <= 2'b00;
          out_payload   <= in_payload;
          out_route_req <= r_f;
          typ_q         <= in_pkt_type;
          fx_q          <= pg_node_x;
          fy_q          <= pg_node_y;
        end else if (drop_in) begin
          drop_pulse <= 1'b1;
          out_valid  <= 1'b0;
        end else begin
          out_valid     <= 1'b1;
          out_tgt_x     <= in_tgt_x;
          out_tgt_y     <= in_tgt_y;
          out_src_x     <= in_src_x;
          out_src_y     <= in_src_y;
          out_pkt_type  <= in_pkt_type;
          out_payload   <= in_payload;
          out_route_req <= r_in;
        end
      end else if (out_valid && out_ready) begin
        if (state_q == REPL && !n_fin) begin
          out_tgt_x     <= n_x;
          out_tgt_y     <= n_y;
          out_route_req <= r_n;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pg_mcast_route_stage.sv
// Directed bench for pg_mcast_route_stage.
// Two instances: node (3,3) arriving N, node (7,7) arriving W.
module tb_pg_mcast_route_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_tgt_x, in_tgt_y, in_src_x, in_src_y;
  logic [1:0]  in_pkt_type;
  logic [31:0] in_payload;
  logic        pg_en;
  logic [2:0]  pg_node_x, pg_node_y;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_drop;
  logic [2:0]  a_tgt_x, a_tgt_y, a_src_x, a_src_y;
  logic [1:0]  a_type;
  logic [31:0] a_payload;
  logic [4:0]  a_req;

  logic        b_in_ready, b_out_valid, b_drop;
  logic [2:0]  b_tgt_x, b_tgt_y, b_src_x, b_src_y;
  logic [1:0]  b_type;
  logic [31:0] b_payload;
  logic [4:0]  b_req;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pg_mcast_route_stage #(
    .LOCAL_X(3), .LOCAL_Y(3), .ROUTER_ID(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_tgt_x(in_tgt_x), .in_tgt_y(in_tgt_y),
    .in_src_x(in_src_x), .in_src_y(in_src_y),
    .in_pkt_type(in_pkt_type), .in_payload(in_payload),
    .pg_en(pg_en), .pg_node_x(pg_node_x), .pg_node_y(pg_node_y),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_tgt_x(a_tgt_x), .out_tgt_y(a_tgt_y),
    .out_src_x(a_src_x), .out_src_y(a_src_y),
    .out_pkt_type(a_type), .out_payload(a_payload),
    .out_route_req(a_req), .drop_pulse(a_drop)
  );

  pg_mcast_route_stage #(
    .LOCAL_X(7), .LOCAL_Y(7), .ROUTER_ID(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_tgt_x(in_tgt_x), .in_tgt_y(in_tgt_y),
    .in_src_x(in_src_x), .in_src_y(in_src_y),
    .in_pkt_type(in_pkt_type), .in_payload(in_payload),
    .pg_en(pg_en), .pg_node_x(pg_node_x), .pg_node_y(pg_node_y),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_tgt_x(b_tgt_x), .out_tgt_y(b_tgt_y),
    .out_src_x(b_src_x), .out_src_y(b_src_y),
    .out_pkt_type(b_type), .out_payload(b_payload),
    .out_route_req(b_req), .drop_pulse(b_drop)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] tx, input logic [2:0] ty,
                      input logic [2:0] sx, input logic [2:0] sy,
                      input logic [1:0] t, input logic pg,
                      input logic [2:0] fx, input logic [2:0] fy);
    int n;
    n = 0;
    in_tgt_x    = tx;
    in_tgt_y    = ty;
    in_src_x    = sx;
    in_src_y    = sy;
    in_pkt_type = t;
    pg_en       = pg;
    pg_node_x   = fx;
    pg_node_y   = fy;
    in_valid    = 1'b1;
    while (!a_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(n < 20), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ys[7] = '{0, 1, 2, 3, 4, 6, 7};
    int idx, cyc;
    logic ph, stalled;
    logic [5:0] prev;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_tgt_x = '0; in_tgt_y = '0;
    in_src_x = '0; in_src_y = '0;
    in_pkt_type = '0;
    in_payload = 32'h1234_5678;
    pg_en = 1'b0; pg_node_x = '0; pg_node_y = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", a_out_valid, 0);
    check("rst_req", a_req, 0);
    check("rst_drop", a_drop, 0);
    check("rst_tgt", a_tgt_x, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", a_in_ready, 1);

    send(5, 1, 0, 0, 2'b00, 0, 0, 0);
    check("t1_valid", a_out_valid, 1);
    check("t1_req", a_req, 5'b01000);
    check("t1_tgt", {a_tgt_x, a_tgt_y}, {3'd5, 3'd1});
    check("t1_pay", a_payload, 32'h1234_5678);
    @(negedge clk);
    check("t1_drain", a_out_valid, 0);

    send(0, 0, 7, 7, 2'b11, 0, 0, 0);
    check("t2_b_valid", b_out_valid, 1);
    check("t2_b_req", b_req, 5'b10100);
    check("t2_a_req", a_req, 5'b10110);
    @(negedge clk);

    send(3, 0, 0, 0, 2'b01, 0, 0, 0);
    check("col_a_req", a_req, 5'b10100);
    check("col_b_req", b_req, 5'b00000);
    check("col_b_valid", b_out_valid, 1);
    @(negedge clk);

    send(6, 3, 0, 0, 2'b00, 1, 4, 3);
    check("t3_req", a_req, 5'b00001);
    @(negedge clk);
    send(4, 3, 0, 0, 2'b00, 1, 4, 3);
    check("t3_drop", a_drop, 1);
    check("t3_nobeat", a_out_valid, 0);
    @(negedge clk);
    check("t3_pulse1", a_drop, 0);
    check("t3_nobeat2", a_out_valid, 0);

    send(3, 6, 0, 0, 2'b00, 1, 3, 4);
    check("ns_detour", a_req, 5'b00010);
    @(negedge clk);

    send(2, 0, 0, 0, 2'b01, 1, 2, 5);
    for (int i = 0; i < 7; i++) begin
      check("t4_valid", a_out_valid, 1);
      check("t4_tgt", {a_tgt_x, a_tgt_y}, {3'd2, 3'(ys[i])});
      check("t4_type", a_type, 0);
      check("t4_req", a_req, 5'b00010);
      check("t4_rdy", a_in_ready, 0);
      @(negedge clk);
    end
    check("t4_end", a_out_valid, 0);
    check("t4_idle", a_in_ready, 1);

    out_ready = 1'b0;
    send(2, 0, 0, 0, 2'b01, 1, 2, 5);
    idx = 0; cyc = 0; ph = 1'b0;
    stalled = 1'b0; prev = '0;
    while (idx < 7 && cyc < 40) begin
      if (a_out_valid) begin
        if (stalled) check("t5_hold", {a_tgt_x, a_tgt_y}, prev);
        prev = {a_tgt_x, a_tgt_y};
        out_ready = ph;
        if (ph) begin
          check("t5_tgt", {a_tgt_x, a_tgt_y}, {3'd2, 3'(ys[idx])});
          idx++;
        end
        stalled = !ph;
      end
      ph = !ph;
      cyc++;
      @(negedge clk);
    end
    check("t5_count", idx, 7);
    out_ready = 1'b1;
    check("t5_end", a_out_valid, 0);

    send(0, 0, 0, 0, 2'b11, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      check("t6_valid", a_out_valid, 1);
      if (k == 0) begin
        check("t6_first", {a_tgt_x, a_tgt_y}, {3'd1, 3'd0});
        check("t6_req", a_req, 5'b00010);
      end
      if (k == 9) check("t6_c10", {a_tgt_x, a_tgt_y}, {3'd2, 3'd1});
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", a_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rdy", a_in_ready, 1);
    check("t6_idle", a_out_valid, 0);
    send(5, 1, 0, 0, 2'b00, 0, 0, 0);
    check("t6_uni_v", a_out_valid, 1);
    check("t6_uni_req", a_req, 5'b01000);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
